// File: rtl/wasm_run_ctrl.sv
// Host-side run controller for the WASM core: streams a program image into instruction
// memory, supervises execution with a cycle timeout, then streams back a line-memory window.
module wasm_run_ctrl #(
    parameter int          INSTR_W = 64,
    parameter int          IADDR_W = 15,
    parameter int          LADDR_W = 9,
    parameter int          DATA_W  = 32,
    parameter logic [31:0] TIMEOUT = 32'd1_000_000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [IADDR_W:0]   i_instr_len,
    input  logic [LADDR_W-1:0] i_rd_base,
    input  logic [LADDR_W:0]   i_rd_cnt,
    input  logic               i_src_vld,
    output logic               o_src_rdy,
    input  logic [INSTR_W-1:0] i_src_data,
    output logic               o_instr_mem_wr_vld,
    output logic [IADDR_W-1:0] o_instr_mem_wr_addr,
    output logic [INSTR_W-1:0] o_instr_mem_wr_data,
    output logic               o_instr_mem_wr_finish,
    input  logic               i_instr_mem_wr_rdy,
    input  logic [1:0]         i_work_state,
    output logic               o_line_mem_rd_rdy,
    output logic [LADDR_W-1:0] o_line_mem_rd_addr,
    input  logic [DATA_W-1:0]  i_line_mem_rd_data,
    output logic               o_res_vld,
    input  logic               i_res_rdy,
    output logic [DATA_W-1:0]  o_res_data,
    output logic [LADDR_W-1:0] o_res_addr,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err,
    output logic [31:0]        o_cycle_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FINISH, S_RUN, S_RD_ADDR, S_RD_WAIT, S_RD_OUT, S_DONE
    } state_t;

    state_t             state;
    logic [IADDR_W:0]   len_q;
    logic [IADDR_W:0]   acc_cnt;
    logic [LADDR_W-1:0] base_q;
    logic [LADDR_W:0]   cnt_q;
    logic [LADDR_W:0]   rd_k;

    logic [IADDR_W:0]   acc_nxt;
    logic [LADDR_W:0]   k_nxt;
    logic [32:0]        cyc_nxt;

    assign acc_nxt = acc_cnt + (IADDR_W+1)'(1);
    assign k_nxt   = rd_k + (LADDR_W+1)'(1);
    assign cyc_nxt = {1'b0, o_cycle_cnt} + 33'd1;

    // Ready follows the core combinationally so a stalled core never loses a beat.
    assign o_src_rdy = (state == S_LOAD) && i_instr_mem_wr_rdy;
    assign o_busy    = (state != S_IDLE);

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state                 <= S_IDLE;
            len_q                 <= '0;
            acc_cnt               <= '0;
            base_q                <= '0;
            cnt_q                 <= '0;
            rd_k                  <= '0;
            o_instr_mem_wr_vld    <= 1'b0;
            o_instr_mem_wr_addr   <= '0;
            o_instr_mem_wr_data   <= '0;
            o_instr_mem_wr_finish <= 1'b0;
            o_line_mem_rd_rdy     <= 1'b0;
            o_line_mem_rd_addr    <= '0;
            o_res_vld             <= 1'b0;
            o_res_data            <= '0;
            o_res_addr            <= '0;
            o_done                <= 1'b0;
            o_err                 <= 1'b0;
            o_cycle_cnt           <= '0;
        end else begin
            o_instr_mem_wr_vld    <= 1'b0;
            o_instr_mem_wr_finish <= 1'b0;
            o_done                <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start && (i_instr_len != '0)) begin
                        len_q       <= i_instr_len;
                        base_q      <= i_rd_base;
                        cnt_q       <= i_rd_cnt;
                        acc_cnt     <= '0;
                        o_err       <= 1'b0;
                        o_cycle_cnt <= '0;
                        state       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (i_src_vld && o_src_rdy) begin
                        o_instr_mem_wr_vld  <= 1'b1;
                        o_instr_mem_wr_addr <= acc_cnt[IADDR_W-1:0];
                        o_instr_mem_wr_data <= i_src_data;
                        acc_cnt             <= acc_nxt;
                        if (acc_nxt == len_q) state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    o_instr_mem_wr_finish <= 1'b1;
                    state                 <= S_RUN;
                end
                S_RUN: begin
                    if (i_work_state == 2'b11) begin
                        if (cnt_q == '0) begin
                            o_done <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            rd_k               <= '0;
                            o_line_mem_rd_addr <= base_q;
                            o_line_mem_rd_rdy  <= 1'b1;
                            state              <= S_RD_ADDR;
                        end
                    end else begin
                        if (o_cycle_cnt != '1) o_cycle_cnt <= cyc_nxt[31:0];
                        // Abort in the same edge the count lands on the limit.
                        if (cyc_nxt >= {1'b0, TIMEOUT}) begin
                            o_err  <= 1'b1;
                            o_done <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end
                S_RD_ADDR: state <= S_RD_WAIT;
                S_RD_WAIT: begin
                    o_res_data <= i_line_mem_rd_data;
                    o_res_addr <= o_line_mem_rd_addr;
                    o_res_vld  <= 1'b1;
                    state      <= S_RD_OUT;
                end
                S_RD_OUT: begin
                    if (i_res_rdy) begin
                        o_res_vld <= 1'b0;
                        if (k_nxt < cnt_q) begin
                            rd_k               <= k_nxt;
                            o_line_mem_rd_addr <= base_q + k_nxt[LADDR_W-1:0];
                            state              <= S_RD_ADDR;
                        end else begin
                            o_line_mem_rd_rdy <= 1'b0;
                            o_done            <= 1'b1;
                            state             <= S_DONE;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wasm_run_ctrl.sv
// Directed + randomized bench for wasm_run_ctrl; a second instance with a short timeout
// exercises the abort path.
module tb_wasm_run_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, start_to, src_vld, wr_rdy, res_rdy;
    logic [15:0] instr_len;
    logic [8:0]  rd_base;
    logic [9:0]  rd_cnt;
    logic [63:0] src_data;
    logic [1:0]  work_state;
    logic [31:0] line_rd_data;

    logic        src_rdy, wr_vld, fin, rd_rdy, res_vld, busy, done, err;
    logic [14:0] wr_addr;
    logic [63:0] wr_data;
    logic [8:0]  rd_addr, res_addr;
    logic [31:0] res_data, cycle_cnt;

    logic        to_src_rdy, to_wr_vld, to_fin, to_rd_rdy, to_res_vld, to_busy, to_done, to_err;
    logic [14:0] to_wr_addr;
    logic [63:0] to_wr_data;
    logic [8:0]  to_rd_addr, to_res_addr;
    logic [31:0] to_res_data, to_cycle_cnt;

    int total = 0, bad = 0, cyc = 0;
    int fin_cnt = 0, fin_cyc = 0, last_wr_cyc = 0, done_cnt = 0;
    bit to_rd_seen = 1'b0;
    logic [63:0] exp_words[$];
    logic [14:0] beat_addr[$];
    logic [63:0] beat_data[$];
    logic [31:0] mem_seed;

    wasm_run_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_instr_len(instr_len),
        .i_rd_base(rd_base), .i_rd_cnt(rd_cnt), .i_src_vld(src_vld), .o_src_rdy(src_rdy),
        .i_src_data(src_data), .o_instr_mem_wr_vld(wr_vld), .o_instr_mem_wr_addr(wr_addr),
        .o_instr_mem_wr_data(wr_data), .o_instr_mem_wr_finish(fin),
        .i_instr_mem_wr_rdy(wr_rdy), .i_work_state(work_state), .o_line_mem_rd_rdy(rd_rdy),
        .o_line_mem_rd_addr(rd_addr), .i_line_mem_rd_data(line_rd_data), .o_res_vld(res_vld),
        .i_res_rdy(res_rdy), .o_res_data(res_data), .o_res_addr(res_addr), .o_busy(busy),
        .o_done(done), .o_err(err), .o_cycle_cnt(cycle_cnt)
    );

    wasm_run_ctrl #(.TIMEOUT(32'd100)) dut_to (
        .i_clk(clk), .i_rst(rst), .i_start(start_to), .i_instr_len(instr_len),
        .i_rd_base(rd_base), .i_rd_cnt(rd_cnt), .i_src_vld(src_vld), .o_src_rdy(to_src_rdy),
        .i_src_data(src_data), .o_instr_mem_wr_vld(to_wr_vld), .o_instr_mem_wr_addr(to_wr_addr),
        .o_instr_mem_wr_data(to_wr_data), .o_instr_mem_wr_finish(to_fin),
        .i_instr_mem_wr_rdy(wr_rdy), .i_work_state(work_state), .o_line_mem_rd_rdy(to_rd_rdy),
        .o_line_mem_rd_addr(to_rd_addr), .i_line_mem_rd_data(line_rd_data),
        .o_res_vld(to_res_vld), .i_res_rdy(res_rdy), .o_res_data(to_res_data),
        .o_res_addr(to_res_addr), .o_busy(to_busy), .o_done(to_done), .o_err(to_err),
        .o_cycle_cnt(to_cycle_cnt)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Line memory model: content is a seeded hash of the address, one cycle of read latency.
    function automatic logic [31:0] lmem(input logic [8:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ mem_seed;
    endfunction

    always @(posedge clk) line_rd_data <= lmem(rd_addr);

    always @(negedge clk) begin
        if (wr_vld) begin
            beat_addr.push_back(wr_addr);
            beat_data.push_back(wr_data);
            last_wr_cyc = cyc;
        end
        if (fin) begin
            fin_cnt++;
            fin_cyc = cyc;
        end
        if (done) done_cnt++;
        if (to_rd_rdy || to_res_vld) to_rd_seen = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=time limit expected=summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},    64'(busy), 64'd0);
        check({tag, "_src_rdy"}, 64'(src_rdy), 64'd0);
        check({tag, "_wr_vld"},  64'(wr_vld), 64'd0);
        check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        check({tag, "_wr_data"}, wr_data, 64'd0);
        check({tag, "_finish"},  64'(fin), 64'd0);
        check({tag, "_rd_rdy"},  64'(rd_rdy), 64'd0);
        check({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
        check({tag, "_res_vld"}, 64'(res_vld), 64'd0);
        check({tag, "_res_dat"}, 64'(res_data), 64'd0);
        check({tag, "_res_adr"}, 64'(res_addr), 64'd0);
        check({tag, "_done"},    64'(done), 64'd0);
        check({tag, "_err"},     64'(err), 64'd0);
        check({tag, "_cyc_cnt"}, 64'(cycle_cnt), 64'd0);
    endtask

    task automatic start_run(input bit sel, input int len, input int base, input int cnt,
                             input bit expect_busy);
        @(posedge clk); #1;
        instr_len = 16'(len);
        rd_base   = 9'(base);
        rd_cnt    = 10'(cnt);
        if (sel) start_to = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        start_to = 1'b0;
        @(negedge clk);
        check("busy_after_start", 64'(sel ? to_busy : busy), 64'(expect_busy));
        check("src_rdy_after_start", 64'(sel ? to_src_rdy : src_rdy), 64'(expect_busy));
        @(posedge clk); #1;
    endtask

    task automatic load(input bit sel, input int n, input bit rnd, input int stop_at);
        int i = 0;
        int budget = 0;
        bit hs;
        while (i < n && i != stop_at && budget < 5000) begin
            src_vld  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            wr_rdy   = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
            src_data = exp_words[i];
            @(negedge clk);
            hs = src_vld && (sel ? to_src_rdy : src_rdy);
            @(posedge clk); #1;
            if (hs) i++;
            budget++;
        end
        src_vld = 1'b0;
        wr_rdy  = 1'b1;
        check("load_in_budget", 64'(budget < 5000), 64'd1);
    endtask

    task automatic wait_fin(input bit sel, output int f);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(sel ? to_fin : fin) && t < 20);
        check("finish_seen", 64'(sel ? to_fin : fin), 64'd1);
        check("src_rdy_low_after_load", 64'(sel ? to_src_rdy : src_rdy), 64'd0);
        f = cyc;
    endtask

    task automatic check_beats(input int n, input int fin0);
        check("beat_count", 64'(beat_addr.size()), 64'(n));
        for (int i = 0; i < n && i < beat_addr.size(); i++) begin
            check("beat_addr", 64'(beat_addr[i]), 64'(i));
            check("beat_data", beat_data[i], exp_words[i]);
        end
        check("finish_count", 64'(fin_cnt - fin0), 64'd1);
        check("finish_after_last_beat", 64'(fin_cyc - last_wr_cyc), 64'd1);
    endtask

    // Entered on the negedge of the finish-pulse cycle (first RUN cycle).
    task automatic run_and_read(input int n_run, input int base, input int cnt,
                                input int stall_word);
        int r, t, s, d0;
        logic [8:0]  ea;
        logic [31:0] ed;
        repeat (n_run) @(posedge clk);
        #1;
        d0         = done_cnt;
        work_state = 2'b11;
        r          = cyc;
        @(posedge clk); #1;
        work_state = 2'b00;
        @(negedge clk);
        check("cycle_cnt", 64'(cycle_cnt), 64'(n_run));
        check("first_rd_rdy", 64'(rd_rdy), 64'd1);
        check("first_rd_addr", 64'(rd_addr), 64'(base % 512));
        for (int w = 0; w < cnt; w++) begin
            t = 0;
            while (!res_vld && t < 10) begin
                @(negedge clk);
                t++;
            end
            check("res_vld_seen", 64'(res_vld), 64'd1);
            if (w == 0) check("res_latency", 64'(cyc - r), 64'd3);
            ea = 9'((base + w) % 512);
            ed = lmem(ea);
            check("res_addr", 64'(res_addr), 64'(ea));
            check("res_data", 64'(res_data), 64'(ed));
            check("rd_rdy_held", 64'(rd_rdy), 64'd1);
            s = (w == stall_word) ? 5 : int'($urandom_range(0, 2));
            repeat (s) begin
                @(negedge clk);
                check("stall_vld", 64'(res_vld), 64'd1);
                check("stall_data", 64'(res_data), 64'(ed));
                check("stall_addr", 64'(res_addr), 64'(ea));
            end
            res_rdy = 1'b1;
            @(posedge clk); #1;
            res_rdy = 1'b0;
            @(negedge clk);
            if (w < cnt - 1) check("no_early_done", 64'(done), 64'd0);
        end
        check("done_pulse", 64'(done), 64'd1);
        check("busy_in_done", 64'(busy), 64'd1);
        check("res_vld_low_at_done", 64'(res_vld), 64'd0);
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        check("idle_after_done", 64'(busy), 64'd0);
        check("rd_rdy_low_after", 64'(rd_rdy), 64'd0);
        #1;
        check("done_count", 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        int f, fin0, t;
        mem_seed   = $urandom;
        rst        = 1'b1;
        start      = 1'b0;
        start_to   = 1'b0;
        instr_len  = '0;
        rd_base    = '0;
        rd_cnt     = '0;
        src_vld    = 1'b0;
        src_data   = '0;
        wr_rdy     = 1'b1;
        work_state = 2'b00;
        res_rdy    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // 300-word ramp load, 500 RUN cycles, 10-word readback with a stall on word 3.
        exp_words.delete();
        for (int i = 0; i < 300; i++) exp_words.push_back({32'(32'hA5A5_0000 + i), 32'(i)});
        beat_addr.delete();
        beat_data.delete();
        fin0 = fin_cnt;
        start_run(1'b0, 300, 'h100, 10, 1'b1);
        load(1'b0, 300, 1'b0, -1);
        wait_fin(1'b0, f);
        run_and_read(500, 'h100, 10, 3);
        check_beats(300, fin0);

        // 16 random words with a flapping core ready, readback window wrapping past 0x1FF.
        exp_words.delete();
        for (int i = 0; i < 16; i++) exp_words.push_back({$urandom, $urandom});
        beat_addr.delete();
        beat_data.delete();
        fin0 = fin_cnt;
        start_run(1'b0, 16, 'h1FE, 4, 1'b1);
        load(1'b0, 16, 1'b1, -1);
        wait_fin(1'b0, f);
        run_and_read(int'($urandom_range(1, 50)), 'h1FE, 4, -1);
        check_beats(16, fin0);

        // Timeout on the short-limit instance: core never finishes.
        exp_words.delete();
        for (int i = 0; i < 2; i++) exp_words.push_back({$urandom, $urandom});
        start_run(1'b1, 2, 0, 3, 1'b1);
        load(1'b1, 2, 1'b0, -1);
        wait_fin(1'b1, f);
        t = 0;
        while (!to_done && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("to_done_seen", 64'(to_done), 64'd1);
        check("to_done_cycle", 64'(cyc - f), 64'd100);
        check("to_err_set", 64'(to_err), 64'd1);
        check("to_cycle_cnt", 64'(to_cycle_cnt), 64'd100);
        @(negedge clk);
        check("to_err_sticky", 64'(to_err), 64'd1);
        check("to_idle", 64'(to_busy), 64'd0);
        check("to_done_one_cycle", 64'(to_done), 64'd0);
        #1;
        check("to_no_readback", 64'(to_rd_seen), 64'd0);

        // Next start clears the error; rd_cnt=0 ends the run with no readback.
        start_run(1'b1, 1, 0, 0, 1'b1);
        check("to_err_cleared", 64'(to_err), 64'd0);
        check("to_cyc_cleared", 64'(to_cycle_cnt), 64'd0);
        load(1'b1, 1, 1'b0, -1);
        wait_fin(1'b1, f);
        @(posedge clk); #1;
        work_state = 2'b11;
        @(posedge clk); #1;
        work_state = 2'b00;
        @(negedge clk);
        check("to_cnt0_done", 64'(to_done), 64'd1);
        check("to_cnt0_err", 64'(to_err), 64'd0);
        check("to_cnt0_cycles", 64'(to_cycle_cnt), 64'd1);
        check("to_cnt0_no_rd", 64'(to_rd_rdy), 64'd0);

        // Reset in the middle of a load, then a zero-length start.
        exp_words.delete();
        for (int i = 0; i < 20; i++) exp_words.push_back({$urandom, $urandom});
        beat_addr.delete();
        beat_data.delete();
        fin0 = fin_cnt;
        start_run(1'b0, 20, 0, 1, 1'b1);
        load(1'b0, 20, 1'b0, 7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("rst_mid_load");
        repeat (10) @(negedge clk);
        #1;
        check("no_finish_after_abort", 64'(fin_cnt - fin0), 64'd0);
        check("beats_before_abort", 64'(beat_addr.size()), 64'd7);
        start_run(1'b0, 0, 0, 0, 1'b0);
        repeat (5) begin
            @(negedge clk);
            check("len0_stays_idle", 64'(busy), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
